mul_hilo_ctrl: RTL

Sequencing controller for the iterative 32x32 shift-add multiplier in the single-cycle CPU. It accepts multiply requests from the control unit and drives the multiplier's start pulse and operands. It counts the multiplier's fixed latency, captures the 64-bit product into architectural HI/LO registers, and stalls the CPU on MFHI/MFLO reads and new multiplies until the result is committed.

---
 rtl/mul_ctrl_pkg.sv | 16 +
 rtl/mul_sign_adjust.sv | 18 +
 rtl/mul_hilo_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply sequencing controller.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } mul_state_e;

    localparam logic MF_SEL_LO       = 1'b0;
    localparam logic MF_SEL_HI       = 1'b1;
    localparam int   MUL_LATENCY_DEF = 33;
    localparam int   CNT_W           = 7;

endpackage

// File: rtl/mul_sign_adjust.sv
// Sign conditioning around an unsigned multiplier: operand magnitudes in,
// optional 64-bit two's-complement negation of the product out.
module mul_sign_adjust (
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        neg,
    input  logic [63:0] prod_in,
    output logic [31:0] mag_a,
    output logic [31:0] mag_b,
    output logic [63:0] prod_out
);

    // -2^31 maps onto 0x80000000, which is representable as an unsigned magnitude
    assign mag_a    = op_a[31] ? (~op_a + 32'd1) : op_a;
    assign mag_b    = op_b[31] ? (~op_b + 32'd1) : op_b;
    assign prod_out = neg ? (~prod_in + 64'd1) : prod_in;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Sequencing controller for the iterative 32x32 multiplier with HI/LO commit.
// Optional signed support is compiled in with the MULCTRL_SIGNED_EN macro.
module mul_hilo_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mul_req,
    input  logic        mul_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mf_req,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    output logic        mf_valid,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        m_start,
    output logic [31:0] m_dataA,
    output logic [31:0] m_dataB,
    input  logic [63:0] m_ans
);

    mul_state_e       state;
    mul_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic [31:0]      opa_cond;
    logic [31:0]      opb_cond;
    logic [63:0]      prod_adj;

`ifdef MULCTRL_SIGNED_EN
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        sign_neg;

    mul_sign_adjust u_sign_adjust (
        .op_a     (op_a),
        .op_b     (op_b),
        .neg      (sign_neg),
        .prod_in  (m_ans),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .prod_out (prod_adj)
    );

    assign opa_cond = mul_signed ? mag_a : op_a;
    assign opb_cond = mul_signed ? mag_b : op_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_neg <= 1'b0;
        end else if (accept) begin
            sign_neg <= mul_signed & (op_a[31] ^ op_b[31]);
        end
    end
`else
    logic unused_mul_signed;

    assign unused_mul_signed = mul_signed;
    assign opa_cond          = op_a;
    assign opb_cond          = op_b;
    assign prod_adj          = m_ans;
`endif

    assign accept = (state == IDLE) && mul_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == CNT_W'(MUL_LATENCY - 1)) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands stay registered from acceptance until the product is committed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            m_start <= 1'b0;
            m_dataA <= '0;
            m_dataB <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            m_start <= accept;
            case (state)
                IDLE: begin
                    if (mul_req) begin
                        m_dataA <= opa_cond;
                        m_dataB <= opb_cond;
                    end
                end
                ISSUE:   cnt <= '0;
                WAIT:    cnt <= cnt + 1'b1;
                CAPTURE: {hi, lo} <= prod_adj;
                default: cnt <= '0;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign stall    = (mul_req | mf_req) & busy;
    assign mf_valid = mf_req & ~busy;
    // Reads see the committed registers, so a read alongside a new multiply returns old HI/LO.
    assign mf_data  = (mf_sel == MF_SEL_HI) ? hi : lo;

endmodule
